multi_alarm_timekeeper: RTL and testbench
=========================================

Name: multi_alarm_timekeeper

Overview:
Next-generation timekeeping core. It replaces the multi-clock timer and adjust-register pair with a single-clock BCD HH:MM:SS counter driven by a built-in prescaler. It adds runtime 12/24 h display formatting, validated time load, and NUM_ALARMS alarm channels with ring timeout and snooze. It feeds the LED display driver; the adjust UI drives its load and alarm-write ports.

Parameters:
CLK_RATE_HZ, 1_000_000, clk frequency; prescaler terminal count = CLK_RATE_HZ-1
NUM_ALARMS, 2, alarm channels (1..8)
SNOOZE_MINUTES, 5, snooze delay in minutes (1..59)
RING_SECONDS, 60, ticks an alarm rings before auto-clear (1..255)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
time_bcd  out  24  internal 24 h time, HH[23:16] MM[15:8] SS[7:0], two BCD nibbles each
disp_bcd  out  24  display time; hours reformatted when hours_12h=1
disp_pm  out  1  1 when hour>=12 (valid in both modes)
tick_1hz  out  1  one-cycle pulse per second
hours_12h  in  1  display mode select
load_strobe  in  1  one-cycle request to load load_bcd
load_bcd  in  24  new time, same layout as time_bcd
load_error  out  1  one-cycle pulse: load rejected
alarm_wr_en  in  1  write alarm channel
alarm_wr_index  in  AW  channel index, AW = max(1,$clog2(NUM_ALARMS))
alarm_wr_bcd  in  16  alarm HHMM (24 h BCD)
alarm_enable  in  NUM_ALARMS  per-channel enable (level)
snooze  in  1  one-cycle pulse: snooze all ringing channels
dismiss  in  1  one-cycle pulse: clear all ringing and snoozed channels
alarm_ringing  out  NUM_ALARMS  per-channel ringing flag

Behaviour:
- Reset values: time 00:00:00; prescaler 0; tick_1hz, load_error, alarm_ringing all 0; alarm registers 00:00; snooze armed flags 0; ring counters 0.
- Prescaler counts 0..CLK_RATE_HZ-1. tick_1hz asserts in the cycle the count equals CLK_RATE_HZ-1; the count returns to 0 in the next cycle. The time registers update in the same edge as the tick, so the new time is visible the cycle after the tick.
- Counting: SS 59->00 carries to MM; MM 59->00 carries to HH; HH 23->00. Stored time is always 24 h BCD.
- Load: on load_strobe, validate load_bcd. Every nibble <=9, SS<=59, MM<=59, HH<=23.
  - Valid: time <= load_bcd next edge; prescaler <= 0, so the next tick occurs a full CLK_RATE_HZ cycles later.
  - Invalid: time unchanged; load_error pulses the next cycle.
  - Load beats a coincident tick: the tick is discarded.
- Display: combinational from time.
  - hours_12h=0: disp_bcd = time_bcd.
  - hours_12h=1: HH 00->12; 13..23 -> HH-12 in BCD; 01..12 unchanged.
  - MM and SS always pass through unchanged.
- Alarm match: channel i matches when it is enabled and the tick updates time to HH:MM:00 equal to its alarm value. On a match, ringing[i] is set and ring counter[i] is cleared. A load that lands on :00 does not trigger a match.
- Ringing: each tick increments ring counter[i]. When the counter reaches RING_SECONDS, ringing[i] clears; snooze is not armed.
- Snooze pulse: for each ringing channel, clear ringing, arm snooze, and set snooze target = current HH:MM + SNOOZE_MINUTES (BCD, wraps at 24:00). When a tick reaches target:00, the channel rings again (snooze re-armable).
- dismiss: clears ringing and snooze-armed on all channels.
- Clearing events: deasserting alarm_enable[i] clears ringing[i] and snooze[i] next edge. alarm_wr_en to channel i stores the value, clears ringing[i] and snooze[i], and suppresses a same-cycle match on i.
- Priority per channel, highest first: alarm write / disable, dismiss, snooze, match, ring timeout.
- A time load does not alter ringing, ring counters, or snooze targets.
- An out-of-range alarm_wr_index (>=NUM_ALARMS) is ignored.
- The stored alarm value is not validated; an invalid value never matches.

Optional Feature:
MULTI_ALARM_TIMEKEEPER_SNOOZE_EN.
- Defined: snooze registers and logic as above.
- Undefined: snooze input ignored; no snooze target registers are built; alarms ring only at their programmed time until dismiss, disable, or timeout.

Test Plan:
CLK_RATE_HZ=4: reset, run 12 cycles -> tick_1hz every 4th cycle, time 00:00:03.
Load 23:59:58, run 3 ticks -> 23:59:59, 00:00:00, 00:00:01. With hours_12h=1 at 13:05:00 -> disp_bcd 01:05:00, disp_pm=1; at 00:30:00 -> 12:30:00, disp_pm=0.
Load 12:60:00 and 2A:00:00 -> load_error pulses, time unchanged. Load coincident with tick -> loaded value exact, next tick 4 cycles later.
Alarm0=07:00, enable=01, load 06:59:59, one tick -> ringing=01. RING_SECONDS=3: clears after 3 ticks. Alarm1 disabled at the same time -> never rings.
Ringing at 07:00, snooze (SNOOZE_MINUTES=5) -> ringing 0, re-rings at 07:05:00. Repeat from alarm 23:58 -> target 00:03 wraps correctly.
Ringing plus snooze and dismiss in the same cycle -> dismiss wins, no re-ring at +5 min. alarm_wr_en to a ringing channel -> ringing cleared next edge.

Source files
------------

// File: rtl/multi_alarm_timekeeper.sv
// multi_alarm_timekeeper: single-clock BCD HH:MM:SS timekeeper with built-in
// prescaler, 12/24 h display formatting, validated time load and NUM_ALARMS
// alarm channels with ring timeout.
// Optional feature: define MULTI_ALARM_TIMEKEEPER_SNOOZE_EN to build the snooze
// target registers and snooze logic. Without it the snooze input is ignored.
`timescale 1ns/1ps
module multi_alarm_timekeeper #(
  parameter int CLK_RATE_HZ    = 1_000_000,
  parameter int NUM_ALARMS     = 2,
  parameter int SNOOZE_MINUTES = 5,
  parameter int RING_SECONDS   = 60,
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [23:0]           time_bcd,
  output logic [23:0]           disp_bcd,
  output logic                  disp_pm,
  output logic                  tick_1hz,
  input  logic                  hours_12h,
  input  logic                  load_strobe,
  input  logic [23:0]           load_bcd,
  output logic                  load_error,
  input  logic                  alarm_wr_en,
  input  logic [AW-1:0]         alarm_wr_index,
  input  logic [15:0]           alarm_wr_bcd,
  input  logic [NUM_ALARMS-1:0] alarm_enable,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic [NUM_ALARMS-1:0] alarm_ringing
);

  localparam int PW = (CLK_RATE_HZ > 1) ? $clog2(CLK_RATE_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_RATE_HZ - 1);
  localparam logic [7:0]    RING_MAX  = 8'(RING_SECONDS);

  // ---------------------------------------------------------------- helpers
  function automatic logic [6:0] bcd_to_bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

  function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  // Increment one BCD field, wrapping to 00 after 'last'.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last)         return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                   return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic valid_time(input logic [23:0] t);
    logic nib_ok;
    nib_ok = (t[3:0] <= 4'd9) && (t[11:8] <= 4'd9) && (t[19:16] <= 4'd9);
    return nib_ok && (t[7:0] <= 8'h59) && (t[15:8] <= 8'h59) && (t[23:16] <= 8'h23);
  endfunction

  // ------------------------------------------------------------ timekeeping
  logic [PW-1:0] presc_q;
  logic [23:0]   time_q;
  logic [23:0]   time_next;
  logic          load_ok;
  logic          tick_eff;

  assign tick_1hz = (presc_q == PRESC_MAX);
  assign load_ok  = load_strobe && valid_time(load_bcd);
  // A valid load restarts the second, so a coincident tick has no effect.
  assign tick_eff = tick_1hz && !load_ok;
  assign time_bcd = time_q;

  // Next time after one second: SS carries into MM, MM into HH, HH wraps at 24.
  always_comb begin
    time_next[7:0]   = bcd_inc(time_q[7:0], 8'h59);
    time_next[15:8]  = time_q[15:8];
    time_next[23:16] = time_q[23:16];
    if (time_q[7:0] == 8'h59) begin
      time_next[15:8] = bcd_inc(time_q[15:8], 8'h59);
      if (time_q[15:8] == 8'h59)
        time_next[23:16] = bcd_inc(time_q[23:16], 8'h23);
    end
  end

  // Prescaler, time register and registered load rejection pulse.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= '0;
      time_q     <= '0;
      load_error <= 1'b0;
    end else begin
      load_error <= load_strobe && !load_ok;
      if (load_ok) begin
        presc_q <= '0;
        time_q  <= load_bcd;
      end else begin
        presc_q <= tick_1hz ? '0 : presc_q + PW'(1);
        if (tick_1hz) time_q <= time_next;
      end
    end
  end

  // ---------------------------------------------------------------- display
  logic [6:0] hour_bin;
  logic [7:0] disp_hh;

  // Hours reformatted for 12 h mode; minutes and seconds pass through.
  always_comb begin
    hour_bin = bcd_to_bin(time_q[23:16]);
    disp_hh  = time_q[23:16];
    if (hours_12h) begin
      if (hour_bin == 7'd0)       disp_hh = 8'h12;
      else if (hour_bin > 7'd12)  disp_hh = bin_to_bcd(hour_bin - 7'd12);
    end
  end

  assign disp_bcd = {disp_hh, time_q[15:0]};
  assign disp_pm  = (hour_bin >= 7'd12);

  // ----------------------------------------------------------------- alarms
  logic [15:0]           alarm_q    [NUM_ALARMS];
  logic [7:0]            ring_cnt_q [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] wr_hit;
  logic [NUM_ALARMS-1:0] fire;

`ifdef MULTI_ALARM_TIMEKEEPER_SNOOZE_EN
  logic [NUM_ALARMS-1:0] snz_armed_q;
  logic [15:0]           snz_target_q [NUM_ALARMS];
  logic [15:0]           snz_target_new;

  // Current HH:MM plus the snooze delay, wrapping at 24:00.
  always_comb begin
    logic [6:0] h;
    logic [6:0] m;
    h = bcd_to_bin(time_q[23:16]);
    m = bcd_to_bin(time_q[15:8]) + 7'(SNOOZE_MINUTES);
    if (m >= 7'd60) begin
      m = m - 7'd60;
      h = (h == 7'd23) ? 7'd0 : h + 7'd1;
    end
    snz_target_new = {bin_to_bcd(h), bin_to_bcd(m)};
  end
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  // Per-channel write decode and match on the tick that lands on HH:MM:00.
  // Out-of-range indices decode to no channel.
  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      wr_hit[i] = alarm_wr_en && (alarm_wr_index == AW'(i));
      fire[i]   = tick_eff && (time_next[7:0] == 8'h00) &&
                  ((alarm_enable[i] && (time_next[23:8] == alarm_q[i]))
`ifdef MULTI_ALARM_TIMEKEEPER_SNOOZE_EN
                   || (snz_armed_q[i] && (time_next[23:8] == snz_target_q[i]))
`endif
                  );
    end
  end

  // Alarm value storage.
  // NOTE: the alarm array is reset because its power-up value must read 00:00;
  // storage without a defined reset value would normally be left unreset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ALARMS; i++) alarm_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++)
        if (wr_hit[i]) alarm_q[i] <= alarm_wr_bcd;
    end
  end

  // Ringing / snooze state per channel; branches ordered by priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alarm_ringing <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) ring_cnt_q[i] <= '0;
`ifdef MULTI_ALARM_TIMEKEEPER_SNOOZE_EN
      snz_armed_q <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) snz_target_q[i] <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (wr_hit[i] || !alarm_enable[i] || dismiss) begin
          alarm_ringing[i] <= 1'b0;
`ifdef MULTI_ALARM_TIMEKEEPER_SNOOZE_EN
          snz_armed_q[i]   <= 1'b0;
        end else if (snooze && alarm_ringing[i]) begin
          alarm_ringing[i] <= 1'b0;
          snz_armed_q[i]   <= 1'b1;
          snz_target_q[i]  <= snz_target_new;
`endif
        end else if (fire[i]) begin
          alarm_ringing[i] <= 1'b1;
          ring_cnt_q[i]    <= '0;
`ifdef MULTI_ALARM_TIMEKEEPER_SNOOZE_EN
          snz_armed_q[i]   <= 1'b0;
`endif
        end else if (tick_eff && alarm_ringing[i]) begin
          ring_cnt_q[i] <= ring_cnt_q[i] + 8'd1;
          if (ring_cnt_q[i] + 8'd1 == RING_MAX) alarm_ringing[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_alarm_timekeeper.sv
// Directed self-checking bench for multi_alarm_timekeeper with CLK_RATE_HZ=4,
// NUM_ALARMS=2, SNOOZE_MINUTES=5, RING_SECONDS=3. Inputs change and outputs are
// sampled on the falling edge.
`timescale 1ns/1ps
module tb_multi_alarm_timekeeper;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] time_bcd, disp_bcd, load_bcd;
  logic        disp_pm, tick_1hz, hours_12h, load_strobe, load_error;
  logic        alarm_wr_en;
  logic [0:0]  alarm_wr_index;
  logic [15:0] alarm_wr_bcd;
  logic [1:0]  alarm_enable, alarm_ringing;
  logic        snooze, dismiss;

  int checks = 0;
  int errors = 0;

  multi_alarm_timekeeper #(
    .CLK_RATE_HZ(4), .NUM_ALARMS(2), .SNOOZE_MINUTES(5), .RING_SECONDS(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .time_bcd(time_bcd), .disp_bcd(disp_bcd),
    .disp_pm(disp_pm), .tick_1hz(tick_1hz), .hours_12h(hours_12h),
    .load_strobe(load_strobe), .load_bcd(load_bcd), .load_error(load_error),
    .alarm_wr_en(alarm_wr_en), .alarm_wr_index(alarm_wr_index),
    .alarm_wr_bcd(alarm_wr_bcd), .alarm_enable(alarm_enable), .snooze(snooze),
    .dismiss(dismiss), .alarm_ringing(alarm_ringing)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_time(input logic [23:0] v);
    load_bcd = v; load_strobe = 1'b1;
    cyc(1);
    load_strobe = 1'b0;
  endtask

  task automatic write_alarm(input logic idx, input logic [15:0] v);
    alarm_wr_index = idx; alarm_wr_bcd = v; alarm_wr_en = 1'b1;
    cyc(1);
    alarm_wr_en = 1'b0;
  endtask

  task automatic pulse(input logic do_snooze, input logic do_dismiss);
    snooze = do_snooze; dismiss = do_dismiss;
    cyc(1);
    snooze = 1'b0; dismiss = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ticks;
    reset_n = 1'b0; hours_12h = 1'b0; load_strobe = 1'b0; load_bcd = '0;
    alarm_wr_en = 1'b0; alarm_wr_index = '0; alarm_wr_bcd = '0;
    alarm_enable = 2'b00; snooze = 1'b0; dismiss = 1'b0;
    cyc(2);
    check("reset_time", time_bcd, 24'h000000);
    check("reset_tick", tick_1hz, 1'b0);
    check("reset_ring", alarm_ringing, 2'b00);
    check("reset_lerr", load_error, 1'b0);
    reset_n = 1'b1;

    // Free run: tick on every 4th cycle, three seconds in 12 cycles.
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (tick_1hz) ticks++;
    end
    check("tick_count", ticks, 3);
    check("run_12", time_bcd, 24'h000003);

    // Midnight rollover.
    load_time(24'h235958);
    check("load_ok", time_bcd, 24'h235958);
    cyc(4); check("roll_1", time_bcd, 24'h235959);
    cyc(4); check("roll_2", time_bcd, 24'h000000);
    cyc(4); check("roll_3", time_bcd, 24'h000001);

    // Display formatting.
    load_time(24'h130500);
    check("disp24", disp_bcd, 24'h130500);
    hours_12h = 1'b1; #1;
    check("disp12_13", disp_bcd, 24'h010500);
    check("pm_13", disp_pm, 1'b1);
    load_time(24'h003000);
    check("disp12_00", disp_bcd, 24'h123000);
    check("pm_00", disp_pm, 1'b0);
    load_time(24'h121500);
    check("disp12_12", disp_bcd, 24'h121500);
    check("pm_12", disp_pm, 1'b1);
    hours_12h = 1'b0;

    // Invalid loads are rejected with a one-cycle error pulse.
    load_time(24'h101010);
    load_time(24'h126000);
    check("bad_mm_err", load_error, 1'b1);
    check("bad_mm_time", time_bcd, 24'h101010);
    cyc(1);
    check("err_pulse_end", load_error, 1'b0);
    load_time(24'h101010);
    load_time(24'h2A0000);
    check("bad_hh_err", load_error, 1'b1);
    check("bad_hh_time", time_bcd, 24'h101010);

    // Load coincident with a tick wins; next tick a full second later.
    load_time(24'h050505);
    cyc(3);
    check("pre_tick", tick_1hz, 1'b1);
    load_time(24'h111111);
    check("coinc_load", time_bcd, 24'h111111);
    cyc(2); check("no_early_tick", tick_1hz, 1'b0);
    cyc(1); check("tick_after_load", tick_1hz, 1'b1);
    cyc(1); check("coinc_next", time_bcd, 24'h111112);

    // Alarm match and ring timeout; channel 1 disabled.
    write_alarm(1'b0, 16'h0700);
    write_alarm(1'b1, 16'h0700);
    alarm_enable = 2'b01;
    load_time(24'h065959);
    cyc(4); check("alarm_ring", alarm_ringing, 2'b01);
    cyc(8); check("ring_hold", alarm_ringing, 2'b01);
    cyc(4); check("ring_timeout", alarm_ringing, 2'b00);

    // Snooze behaviour.
    load_time(24'h065959);
    cyc(4); check("snz_ring", alarm_ringing, 2'b01);
    pulse(1'b1, 1'b0);
`ifdef MULTI_ALARM_TIMEKEEPER_SNOOZE_EN
    check("snz_clear", alarm_ringing, 2'b00);
    load_time(24'h070459);
    cyc(3); check("snz_wait", alarm_ringing, 2'b00);
    cyc(1); check("snz_rering", alarm_ringing, 2'b01);
    pulse(1'b0, 1'b1);
    write_alarm(1'b0, 16'h2358);
    load_time(24'h235759);
    cyc(4); check("wrap_ring", alarm_ringing, 2'b01);
    pulse(1'b1, 1'b0);
    check("wrap_snz", alarm_ringing, 2'b00);
    load_time(24'h000259);
    cyc(4); check("wrap_rering", alarm_ringing, 2'b01);
    check("wrap_time", time_bcd, 24'h000300);
    pulse(1'b1, 1'b1);
    check("dismiss_wins", alarm_ringing, 2'b00);
    load_time(24'h000759);
    cyc(4); check("no_rering", alarm_ringing, 2'b00);
`else
    check("snz_ignored", alarm_ringing, 2'b01);
    pulse(1'b0, 1'b1);
    check("dismiss", alarm_ringing, 2'b00);
`endif

    // Alarm write to a ringing channel clears it.
    write_alarm(1'b0, 16'h2358);
    load_time(24'h235759);
    cyc(4); check("wr_pre", alarm_ringing, 2'b01);
    write_alarm(1'b0, 16'h0700);
    check("wr_clear", alarm_ringing, 2'b00);

    // A load landing on :00 does not match.
    load_time(24'h070000);
    check("load_nomatch", alarm_ringing, 2'b00);
    cyc(2); check("load_nomatch2", alarm_ringing, 2'b00);

    // Disabling clears ringing.
    load_time(24'h065959);
    cyc(4); check("dis_pre", alarm_ringing, 2'b01);
    alarm_enable = 2'b00;
    cyc(1); check("dis_clear", alarm_ringing, 2'b00);
    alarm_enable = 2'b01;
    cyc(1); check("reen_quiet", alarm_ringing, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
